// File: rtl/cnn_pkg.sv
// Shared geometry defaults, reader FSM states and small sizing helpers for the
// output-feature-map reader.
package cnn_pkg;

    localparam int OFM_TO = 7;
    localparam int OFM_R  = 10;
    localparam int OFM_C  = 10;
    localparam int OFM_TR = 2;
    localparam int OFM_TC = 2;
    localparam int OFM_DW = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    // Size of a tile along one axis once the map edge clips it.
    function automatic int tile_dim(input int tile, input int remaining);
        return (tile < remaining) ? tile : remaining;
    endfunction

    // Counter width for n distinct values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_tile_reader_if.sv
// Valid/ready beat stream from the tile reader to the pooling/writeback stage.
interface ofm_tile_reader_if #(
    parameter int TO = cnn_pkg::OFM_TO,
    parameter int R  = cnn_pkg::OFM_R,
    parameter int C  = cnn_pkg::OFM_C,
    parameter int DW = cnn_pkg::OFM_DW
);
    import cnn_pkg::*;

    localparam int CH_W  = cnt_w(TO);
    localparam int ROW_W = cnt_w(R);
    localparam int COL_W = cnt_w(C);

    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [CH_W-1:0]  m_ch;
    logic [ROW_W-1:0] m_row;
    logic [COL_W-1:0] m_col;
    logic             m_tile_last;
    logic             m_frame_last;

    modport master (
        output m_valid, m_data, m_ch, m_row, m_col, m_tile_last, m_frame_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_ch, m_row, m_col, m_tile_last, m_frame_last,
        output m_ready
    );

endinterface

// File: rtl/ofm_tile_addr_gen.sv
// Five-level loop counter (channel, tile-row, tile-col, row-in-tile, col-in-tile)
// with edge-tile clipping; steps one element per advance.
module ofm_tile_addr_gen
    import cnn_pkg::*;
#(
    parameter int TO    = OFM_TO,
    parameter int R     = OFM_R,
    parameter int C     = OFM_C,
    parameter int TR    = OFM_TR,
    parameter int TC    = OFM_TC,
    parameter int CH_W  = cnt_w(TO),
    parameter int ROW_W = cnt_w(R),
    parameter int COL_W = cnt_w(C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CH_W-1:0]  ch,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             tile_last,
    output logic             frame_last
);

    logic [CH_W-1:0]  o_q;
    logic [ROW_W-1:0] tr_q;
    logic [ROW_W-1:0] rr_q;
    logic [COL_W-1:0] tc_q;
    logic [COL_W-1:0] cc_q;
    int               th;
    int               tw;
    logic             cc_end;
    logic             rr_end;
    logic             tc_end;
    logic             tr_end;
    logic             o_end;

    always_comb begin
        th     = tile_dim(TR, R - int'(tr_q));
        tw     = tile_dim(TC, C - int'(tc_q));
        cc_end = (int'(cc_q) == tw - 1);
        rr_end = (int'(rr_q) == th - 1);
        tc_end = (int'(tc_q) + TC >= C);
        tr_end = (int'(tr_q) + TR >= R);
        o_end  = (int'(o_q) == TO - 1);
    end

    // Each level wraps and carries into the next only when all inner levels wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            o_q  <= '0;
            tr_q <= '0;
            rr_q <= '0;
            tc_q <= '0;
            cc_q <= '0;
        end else if (advance) begin
            cc_q <= cc_end ? '0 : cc_q + 1'b1;
            if (cc_end) begin
                rr_q <= rr_end ? '0 : rr_q + 1'b1;
                if (rr_end) begin
                    tc_q <= tc_end ? '0 : tc_q + COL_W'(TC);
                    if (tc_end) begin
                        tr_q <= tr_end ? '0 : tr_q + ROW_W'(TR);
                        if (tr_end) begin
                            o_q <= o_end ? '0 : o_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ch         = o_q;
    assign row        = tr_q + rr_q;
    assign col        = tc_q + cc_q;
    assign tile_last  = cc_end & rr_end;
    assign frame_last = tile_last & tc_end & tr_end & o_end;

endmodule

// File: rtl/ofm_tile_reader.sv
// Output-feature-map tile reader: captures the flat map on start and replays it
// as a valid/ready stream in the engine's loop-tiled order.
module ofm_tile_reader
    import cnn_pkg::*;
#(
    parameter int TO = OFM_TO,
    parameter int R  = OFM_R,
    parameter int C  = OFM_C,
    parameter int TR = OFM_TR,
    parameter int TC = OFM_TC,
    parameter int DW = OFM_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TO*R*C*DW-1:0] ofm_in,
    output logic                 busy,
    output logic                 done,
    ofm_tile_reader_if.master    m
);

    localparam int CH_W  = cnt_w(TO);
    localparam int ROW_W = cnt_w(R);
    localparam int COL_W = cnt_w(C);
    localparam int IDX_W = cnt_w(TO * R * C * DW);

    state_t               state;
    state_t               state_nx;
    logic                 load;
    logic                 clear;
    logic                 advance;
    logic                 vld_p1;
    logic [TO*R*C*DW-1:0] buf_p0;
    logic [CH_W-1:0]      ch;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 tile_last;
    logic                 frame_last;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     base;

    ofm_tile_addr_gen #(
        .TO    (TO),
        .R     (R),
        .C     (C),
        .TR    (TR),
        .TC    (TC),
        .CH_W  (CH_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .advance    (advance),
        .ch         (ch),
        .row        (row),
        .col        (col),
        .tile_last  (tile_last),
        .frame_last (frame_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        clear    = 1'b0;
        advance  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    clear    = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                advance = m.m_ready;
                if (m.m_ready && frame_last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Stage p0: whole map captured once; starts during a frame never reach here.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_p0 <= ofm_in;
        end
    end

    // Stage p1: current beat selected straight from the counters, so a stall holds it.
    always_comb begin
        idx  = IDX_W'((int'(ch) * R + int'(row)) * C + int'(col));
        base = IDX_W'(int'(idx) * DW);
    end

    assign vld_p1         = (state == STREAM);
    assign busy           = vld_p1;
    assign done           = (state == FIN);
    assign m.m_valid      = vld_p1;
    assign m.m_data       = vld_p1 ? buf_p0[base +: DW] : '0;
    assign m.m_ch         = vld_p1 ? ch : '0;
    assign m.m_row        = vld_p1 ? row : '0;
    assign m.m_col        = vld_p1 ? col : '0;
    assign m.m_tile_last  = vld_p1 & tile_last;
    assign m.m_frame_last = vld_p1 & frame_last;

endmodule
